// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light blocks: duration selects, light
// colours and the interval-timer state.
package traffic_pkg;

  typedef enum logic [1:0] {
    BASE_SELECT = 2'b00,
    EXT_SELECT  = 2'b01,
    YEL_SELECT  = 2'b10,
    ZERO_SELECT = 2'b11
  } time_select_e;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_e;

  typedef enum logic {
    TIMER_IDLE = 1'b0,
    TIMER_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/tick_divider.sv
// One-second prescaler: counts 0..TICK_CYCLES-1 while enabled and flags the
// terminal count as a tick. Held at zero whenever disabled or cleared.
module tick_divider #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer behind the traffic-light state machine: loads a selected
// duration on start_timer, counts whole seconds, emits a one-cycle expired.
// Build option: TRAFFIC_TIMER_FAST_EN removes the prescaler (one tick per clk).
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int BASE_SEC    = 6,
  parameter int EXT_SEC     = 3,
  parameter int YEL_SEC     = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [1:0]       time_parameter,
  output logic             expired,
  output logic             running,
  output logic [CNT_W-1:0] remaining
);

  if (BASE_SEC < 0 || BASE_SEC >= (1 << CNT_W) ||
      EXT_SEC  < 0 || EXT_SEC  >= (1 << CNT_W) ||
      YEL_SEC  < 0 || YEL_SEC  >= (1 << CNT_W)) begin : gBadDuration
    $error("traffic_timer: every duration must fit in CNT_W bits");
  end

  if (TICK_CYCLES < 1) begin : gBadTick
    $error("traffic_timer: TICK_CYCLES must be at least 1");
  end

  function automatic logic [CNT_W-1:0] selDuration(input logic [1:0] sel);
    case (sel)
      BASE_SELECT: return CNT_W'(BASE_SEC);
      EXT_SELECT:  return CNT_W'(EXT_SEC);
      YEL_SELECT:  return CNT_W'(YEL_SEC);
      default:     return '0;
    endcase
  endfunction

  timer_state_e     state;
  timer_state_e     stateNext;
  logic [CNT_W-1:0] remainingNext;
  logic             expiredNext;
  logic             runningNext;
  logic             countEnable;
  logic             tick;

  // The prescaler only advances while there are seconds left to count.
  assign countEnable = (state == TIMER_RUN) && (remaining != '0);

`ifdef TRAFFIC_TIMER_FAST_EN
  assign tick = countEnable;
`else
  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) uTickDivider (
    .clk   (clk),
    .reset (reset),
    .clear (start_timer),
    .enable(countEnable),
    .tick  (tick)
  );
`endif

  // start_timer wins over any tick or expiry due on the same edge.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    expiredNext   = 1'b0;
    if (start_timer) begin
      stateNext     = TIMER_RUN;
      remainingNext = selDuration(time_parameter);
    end else begin
      case (state)
        TIMER_RUN: begin
          if (remaining == '0) begin
            expiredNext = 1'b1;
            stateNext   = TIMER_IDLE;
          end else if (tick) begin
            remainingNext = remaining - CNT_W'(1);
          end
        end
        default: begin
          remainingNext = '0;
        end
      endcase
    end
    runningNext = (stateNext == TIMER_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= TIMER_IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      expired   <= expiredNext;
      running   <= runningNext;
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer with a 4-cycle second: drivers queue the
// expected expiry cycles and state samples, a negedge monitor checks them.
module tb_traffic_timer;

  localparam int TICK = 4;

  typedef enum logic [2:0] {
    START_MG, CONT_MG_NO_TRAFFIC, MYEL, START_SG, SYEL
  } up_state_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_timer;
  logic [1:0]  time_parameter;
  logic        expired;
  logic        running;
  logic [3:0]  remaining;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];
  logic [36:0] chk_q[$];
  logic        prev_exp = 1'b0;
  logic [31:0] mon_e;
  logic [36:0] mon_c;

  traffic_timer #(
    .TICK_CYCLES(TICK),
    .BASE_SEC   (6),
    .EXT_SEC    (3),
    .YEL_SEC    (2),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_timer   (start_timer),
    .time_parameter(time_parameter),
    .expired       (expired),
    .running       (running),
    .remaining     (remaining)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Hand-computed durations for the bench parameters.
  function automatic int dur(input logic [1:0] sel);
    case (sel)
      2'b00:   return 6;
      2'b01:   return 3;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (expired === 1'b1) begin
        n_tests++;
        if (prev_exp) begin
          n_fail++;
          $display("FAIL back_to_back_expired cycle=%0d", cyc);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_expired actual cycle=%0d required none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e != cyc) begin
            n_fail++;
            $display("FAIL expired_timing actual cycle=%0d required cycle=%0d", cyc, mon_e);
          end
        end
      end
      while (chk_q.size() > 0 && chk_q[0][36:5] <= cyc) begin
        mon_c = chk_q.pop_front();
        n_tests++;
        if (mon_c[36:5] != cyc || running !== mon_c[4] || remaining !== mon_c[3:0]) begin
          n_fail++;
          $display("FAIL state_sample cycle=%0d due=%0d actual running=%b remaining=%0d required running=%b remaining=%0d",
                   cyc, mon_c[36:5], running, remaining, mon_c[4], mon_c[3:0]);
        end
      end
      prev_exp = (expired === 1'b1);
    end else begin
      prev_exp = 1'b0;
    end
  end

  // driver tasks
  task automatic push_chk(input logic [31:0] at, input logic run, input logic [3:0] rem);
    chk_q.push_back({at, run, rem});
  endtask

  // Caller sits at a negedge; the load edge is the following posedge.
  task automatic start(input logic [1:0] sel, input bit expect_pulse, output logic [31:0] load);
    load = cyc + 1;
    push_chk(load, 1'b1, 4'(dur(sel)));
    if (expect_pulse) exp_q.push_back(load + 32'(dur(sel) * TICK + 1));
    start_timer    = 1'b1;
    time_parameter = sel;
    @(negedge clk);
    start_timer    = 1'b0;
    time_parameter = 2'($urandom_range(0, 3));
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_expired(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (expired === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s actual=no_expired required=expired within 80 cycles", name);
    end
  endtask

  function automatic up_state_e up_next(input up_state_e s);
    case (s)
      START_MG:           return CONT_MG_NO_TRAFFIC;
      CONT_MG_NO_TRAFFIC: return MYEL;
      MYEL:               return START_SG;
      START_SG:           return SYEL;
      default:            return START_MG;
    endcase
  endfunction

  function automatic logic [1:0] up_sel(input up_state_e s);
    case (s)
      START_MG, START_SG:  return 2'b00;
      CONT_MG_NO_TRAFFIC:  return 2'b01;
      default:             return 2'b10;
    endcase
  endfunction

  logic [31:0] l1, l2, l3;
  up_state_e   up_state;
  up_state_e   exp_seq [5];

  initial begin
    exp_seq = '{CONT_MG_NO_TRAFFIC, MYEL, START_SG, SYEL, START_MG};
    reset = 1'b0;
    start_timer = 1'b0;
    time_parameter = 2'b00;
    repeat (2) @(negedge clk);
    check_val("reset_expired", 32'(expired), 0);
    check_val("reset_running", 32'(running), 0);
    check_val("reset_remaining", 32'(remaining), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // EXT: 3,2,1,0 on ticks, expiry 13 edges after load
    start(2'b01, 1, l1);
    push_chk(l1 + 3, 1'b1, 4'd3);
    push_chk(l1 + 4, 1'b1, 4'd2);
    push_chk(l1 + 8, 1'b1, 4'd1);
    push_chk(l1 + 12, 1'b1, 4'd0);
    push_chk(l1 + 13, 1'b0, 4'd0);
    repeat (18) @(negedge clk);

    // ZERO: expiry on the edge after load
    start(2'b11, 1, l1);
    push_chk(l1 + 1, 1'b0, 4'd0);
    push_chk(l1 + 3, 1'b0, 4'd0);
    repeat (6) @(negedge clk);

    // BASE interrupted at remaining=4 by YEL; old interval gives no pulse
    start(2'b00, 0, l1);
    push_chk(l1 + 4, 1'b1, 4'd5);
    push_chk(l1 + 8, 1'b1, 4'd4);
    repeat (8) @(negedge clk);
    start(2'b10, 1, l2);
    push_chk(l2 + 4, 1'b1, 4'd1);
    push_chk(l2 + 8, 1'b1, 4'd0);
    push_chk(l2 + 9, 1'b0, 4'd0);
    repeat (14) @(negedge clk);

    // start_timer during the expired cycle, then ZERO during the next one
    start(2'b01, 1, l1);
    repeat (13) @(negedge clk);
    check_val("expired_before_reload", 32'(expired), 1);
    start(2'b10, 1, l2);
    push_chk(l2 + 8, 1'b1, 4'd0);
    repeat (9) @(negedge clk);
    start(2'b11, 1, l3);
    push_chk(l3 + 1, 1'b0, 4'd0);
    repeat (6) @(negedge clk);

    // asynchronous reset mid-count at remaining=5
    start(2'b00, 0, l1);
    push_chk(l1 + 4, 1'b1, 4'd5);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("midreset_expired", 32'(expired), 0);
    check_val("midreset_running", 32'(running), 0);
    check_val("midreset_remaining", 32'(remaining), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_val("post_reset_running", 32'(running), 0);

    // upstream state machine, no traffic and no walk request
    up_state = START_MG;
    start(up_sel(up_state), 1, l1);
    for (int i = 0; i < 5; i++) begin
      wait_expired("upstream_pulse");
      up_state = up_next(up_state);
      n_tests++;
      if (up_state != exp_seq[i]) begin
        n_fail++;
        $display("FAIL upstream_visit step=%0d actual=%s required=%s", i, up_state.name(), exp_seq[i].name());
      end
      if (i < 4) start(up_sel(up_state), 1, l1);
    end
    repeat (30) @(negedge clk);

    check_val("pending_expired_entries", 32'(exp_q.size()), 0);
    check_val("pending_state_samples", 32'(chk_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Interval timer directly downstream of the traffic-light state machine.
- Loads a duration chosen by the 2-bit time-parameter select whenever start_timer is pulsed, counts it down in whole seconds, then returns a single-cycle expired pulse.
- The pulse advances the state machine exactly one state per interval.
- Also exposes remaining seconds for a countdown display.

Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per one-second tick (100 MHz board clock).
- BASE_SEC, 6: seconds for select 2'b00 (BASE).
- EXT_SEC, 3: seconds for select 2'b01 (EXT).
- YEL_SEC, 2: seconds for select 2'b10 (YEL).
- CNT_W, 4: width of the seconds counter. BASE_SEC, EXT_SEC and YEL_SEC must each be < 2**CNT_W; elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_timer  in  1  load/restart strobe, one cycle wide, synchronous to clk.
- time_parameter  in  2  duration select, sampled only on the edge where start_timer=1: 00 BASE, 01 EXT, 10 YEL, 11 ZERO (0 s).
- expired  out  1  single-cycle pulse when the loaded interval elapses.
- running  out  1  high while a countdown is in progress.
- remaining  out  CNT_W  seconds left in the current interval; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, remaining=0, prescaler=0, expired=0, running=0. All outputs are registered.
- States: IDLE, RUN.
- Load: on a clk edge with start_timer=1, from any state:
  - remaining <= selected duration; ZERO loads 0.
  - prescaler <= 0, state <= RUN, expired <= 0.
  - start_timer has priority over any expiry or tick due on the same edge. A restart mid-count discards the old interval with no pulse.
- RUN, remaining > 0: the prescaler counts 0..TICK_CYCLES-1 and wraps. The edge where prescaler == TICK_CYCLES-1 is a tick, and remaining decrements on it.
- RUN, remaining == 0 (and no start_timer): expired <= 1 for exactly one cycle, state <= IDLE, running <= 0.
- Latency: load of N>0 at edge t0 → remaining reaches 0 at edge t0 + N*TICK_CYCLES → expired high during the cycle after edge t0 + N*TICK_CYCLES + 1.
- ZERO select: expired high during the cycle after edge t0+1.
- IDLE: the prescaler is held at 0 and no further expired pulses occur. The timer never free-runs or re-expires without a new start_timer.
- expired must never be asserted two cycles in a row. The upstream state machine issues its registered start_timer one cycle after seeing expired, and a level expired would advance it twice.
- running = (state == RUN), registered alongside state.
- A start_timer arriving in the same cycle that expired is high is a normal load.
- An asynchronous reset assertion mid-count aborts immediately; no pulse is produced on release.

Optional Feature:
- TRAFFIC_TIMER_FAST_EN defined: prescaler removed; every clk edge in RUN counts as a tick (effective TICK_CYCLES=1). Intended for simulation and LED bring-up.
- Not defined: TICK_CYCLES prescaler as specified above.
- Port list and expired pulse semantics are identical in both builds.

Decomposition:
- Package traffic_pkg holds:
  - select encodings BASE_SELECT/EXT_SELECT/YEL_SELECT/ZERO_SELECT;
  - light encodings RED/YELLOW/GREEN;
  - the timer state enum.
- All traffic blocks share the package.
- One sub-module, tick_divider: the prescaler with sync clear and tick output; bypassed under TRAFFIC_TIMER_FAST_EN.

Test Plan (all with TICK_CYCLES=4, BASE=6, EXT=3, YEL=2):
- Reset asserted low mid-count with remaining=5 → all outputs 0 immediately; no expired after release.
- start_timer with select 01 → remaining 3,2,1,0 on ticks; expired one cycle at cycle 14 after load; running falls with it.
- start_timer with select 11 → expired exactly at cycle 2 after load; remaining stays 0.
- Select 00 loaded, restart with select 10 at remaining=4 → remaining=2; only one expired pulse, 9 cycles after the restart.
- start_timer asserted in the same cycle expired is high → new load accepted; next expired only after the full new interval; never two consecutive expired cycles.
- Drive with the upstream state machine model, trafficSensor=0, pendingWalk=0 → visits START_MG, CONT_MG_NO_TRAFFIC, MYEL, START_SG, SYEL, START_MG with one state per expired pulse.
